// File: rtl/line_code_pkg.sv
// Shared line-code definitions for the Manchester encoder and downstream decoder.
//   line_state_t : encoder FSM state encoding (IDLE / FIRST / SECOND)
//   MAN_ONE      : chip pair sent for a data 1 (first chip in bit 1)
//   MAN_ZERO     : chip pair sent for a data 0
//   LINE_IDLE    : level driven on the line when no word is in flight
package line_code_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIRST  = 2'd1,
        SECOND = 2'd2
    } line_state_t;

    localparam logic [1:0] MAN_ONE   = 2'b10;
    localparam logic [1:0] MAN_ZERO  = 2'b01;
    localparam logic       LINE_IDLE = 1'b0;

    // Chip pair for one data bit; bit [1] goes out first.
    function automatic logic [1:0] man_pair(input logic b);
        return b ? MAN_ONE : MAN_ZERO;
    endfunction

endpackage

// File: rtl/manchester_encoder_if.sv
// Word handshake between a data source and the Manchester encoder.
//   data_in    : word to encode, sampled when data_valid && data_ready
//   data_valid : source holds a valid word
//   data_ready : encoder can take a word this cycle
interface manchester_encoder_if #(
    parameter int unsigned DATA_W = 8
) ();

    logic [DATA_W-1:0] data_in;
    logic              data_valid;
    logic              data_ready;

    modport master (
        output data_in,
        output data_valid,
        input  data_ready
    );

    modport slave (
        input  data_in,
        input  data_valid,
        output data_ready
    );

endinterface

// File: rtl/manchester_encoder.sv
// Parallel-to-serial Manchester encoder, MSB first, one chip per clock.
//   clk            : chip clock, rising edge
//   rst            : asynchronous reset, active low
//   bus            : word handshake (data_in / data_valid / data_ready)
//   manchester_out : registered chip stream
//   line_active    : 1 while manchester_out carries a chip of a word
//   bits_sent      : data bits completed since reset, wraps at 16 bits
module manchester_encoder
    import line_code_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    manchester_encoder_if.slave     bus,
    output logic                    manchester_out,
    output logic                    line_active,
    output logic [15:0]             bits_sent
);

    localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    line_state_t       state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              chip_d;
    logic              active_d;
    logic [1:0]        pair_d;
    logic              last_bit_c;
    logic              take_c;

    // Ready only while idle or on the second chip of the last bit.
    assign last_bit_c     = (state_q == SECOND) && (idx_q == LAST_IDX);
    assign bus.data_ready = (state_q == IDLE) || last_bit_c;
    assign take_c         = bus.data_valid && bus.data_ready;

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            shift_q        <= '0;
            idx_q          <= '0;
            manchester_out <= LINE_IDLE;
            line_active    <= 1'b0;
            bits_sent      <= '0;
        end else begin
            state_q        <= state_d;
            shift_q        <= shift_d;
            idx_q          <= idx_d;
            manchester_out <= chip_d;
            line_active    <= active_d;
            if (state_q == SECOND) begin
                bits_sent <= bits_sent + 16'd1;
            end
        end
    end

    // Next state and datapath.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (take_c) begin
                    shift_d = bus.data_in;
                    idx_d   = '0;
                    state_d = FIRST;
                end
            end
            FIRST: begin
                state_d = SECOND;
            end
            SECOND: begin
                if (!last_bit_c) begin
                    shift_d = shift_q << 1;
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = FIRST;
                end else if (take_c) begin
                    shift_d = bus.data_in;
                    idx_d   = '0;
                    state_d = FIRST;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Next chip follows the next state so the line lines up with the FSM.
    always_comb begin
        chip_d   = LINE_IDLE;
        active_d = 1'b0;
        pair_d   = man_pair(shift_d[DATA_W-1]);
        unique case (state_d)
            FIRST: begin
                chip_d   = pair_d[1];
                active_d = 1'b1;
            end
            SECOND: begin
                chip_d   = pair_d[0];
                active_d = 1'b1;
            end
            default: begin
                chip_d   = LINE_IDLE;
                active_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_manchester_encoder.sv
// Directed bench for manchester_encoder: an 8-bit instance for framing,
// streaming, reset and counter checks, and a 2-bit instance whose chip
// stream is decoded by a small Manchester-to-PAM4 model.
module tb_manchester_encoder;
    import line_code_pkg::*;

    logic clk;
    logic rst;

    manchester_encoder_if #(.DATA_W(8)) bus8 ();
    manchester_encoder_if #(.DATA_W(2)) bus2 ();

    logic        mout8, line8, mout2, line2;
    logic [15:0] cnt8, cnt2;

    manchester_encoder #(.DATA_W(8)) dut8 (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus8.slave),
        .manchester_out (mout8),
        .line_active    (line8),
        .bits_sent      (cnt8)
    );

    manchester_encoder #(.DATA_W(2)) dut2 (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus2.slave),
        .manchester_out (mout2),
        .line_active    (line2),
        .bits_sent      (cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Line monitor: records every active chip, the ready level beside it,
    // and how many separate bursts of activity were seen.
    logic chips8[$];
    logic rdy8[$];
    logic chips2[$];
    int   rises8 = 0;
    int   rises2 = 0;
    logic prev8  = 1'b0;
    logic prev2  = 1'b0;

    always @(negedge clk) begin
        if (line8) begin
            chips8.push_back(mout8);
            rdy8.push_back(bus8.data_ready);
            if (!prev8) rises8++;
        end
        if (line2) begin
            chips2.push_back(mout2);
            if (!prev2) rises2++;
        end
        prev8 = line8;
        prev2 = line2;
    end

    function automatic logic [63:0] vec8(input int base, input int n);
        logic [63:0] v = '0;
        for (int i = 0; i < n; i++) v = (v << 1) | 64'(chips8[base + i]);
        return v;
    endfunction

    function automatic logic [63:0] rvec8(input int base, input int n);
        logic [63:0] v = '0;
        for (int i = 0; i < n; i++) v = (v << 1) | 64'(rdy8[base + i]);
        return v;
    endfunction

    // Reference decoder: chips 10 -> 1, 01 -> 0; anything else is illegal (4).
    function automatic logic [2:0] pam_of(input int base);
        logic [1:0] p_hi, p_lo;
        logic       b_hi, b_lo;
        p_hi = {chips2[base],     chips2[base + 1]};
        p_lo = {chips2[base + 2], chips2[base + 3]};
        if (!((p_hi == 2'b10 || p_hi == 2'b01) && (p_lo == 2'b10 || p_lo == 2'b01)))
            return 3'd4;
        b_hi = (p_hi == 2'b10);
        b_lo = (p_lo == 2'b10);
        return {1'b0, b_hi, b_lo};
    endfunction

    // Offer a word, wait (bounded) for the handshake edge, return on the next negedge.
    task automatic push8(input logic [7:0] w, input bit keep_valid);
        int n = 0;
        bus8.data_in    = w;
        bus8.data_valid = 1'b1;
        while (!bus8.data_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("push8_timeout", 64'd0, 64'd1);
        @(posedge clk);
        @(negedge clk);
        if (!keep_valid) bus8.data_valid = 1'b0;
    endtask

    task automatic push2(input logic [1:0] w, input bit keep_valid);
        int n = 0;
        bus2.data_in    = w;
        bus2.data_valid = 1'b1;
        while (!bus2.data_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("push2_timeout", 64'd0, 64'd1);
        @(posedge clk);
        @(negedge clk);
        if (!keep_valid) bus2.data_valid = 1'b0;
    endtask

    int base;
    int rb;

    initial begin
        rst             = 1'b0;
        bus8.data_in    = '0;
        bus8.data_valid = 1'b0;
        bus2.data_in    = '0;
        bus2.data_valid = 1'b0;

        // Reset held for two cycles while data_valid toggles.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus8.data_in    = 8'hFF;
            bus8.data_valid = ~bus8.data_valid;
            #1;
            chk("rst_mout",  64'(mout8), 64'd0);
            chk("rst_line",  64'(line8), 64'd0);
            chk("rst_ready", 64'(bus8.data_ready), 64'd1);
            chk("rst_cnt",   64'(cnt8), 64'd0);
        end
        @(negedge clk);
        bus8.data_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);

        // Single word 8'hA5.
        base = chips8.size();
        rb   = rises8;
        push8(8'hA5, 1'b0);
        repeat (20) @(negedge clk);
        chk("a5_len",   64'(chips8.size() - base), 64'd16);
        chk("a5_chips", vec8(base, 16), 64'h9966);
        chk("a5_burst", 64'(rises8 - rb), 64'd1);
        chk("a5_cnt",   64'(cnt8), 64'd8);
        chk("a5_idle",  64'({bus8.data_ready, line8, mout8}), 64'b100);

        // Back-to-back 8'hFF then 8'h00 with valid held.
        base = chips8.size();
        rb   = rises8;
        push8(8'hFF, 1'b1);
        push8(8'h00, 1'b0);
        repeat (20) @(negedge clk);
        chk("b2b_len",   64'(chips8.size() - base), 64'd32);
        chk("b2b_chips", vec8(base, 32), 64'hAAAA_5555);
        chk("b2b_ready", rvec8(base, 32), 64'h0001_0001);
        chk("b2b_burst", 64'(rises8 - rb), 64'd1);
        chk("b2b_cnt",   64'(cnt8), 64'd24);

        // End-to-end PAM4 through the 2-bit encoder.
        base = chips2.size();
        rb   = rises2;
        push2(2'b10, 1'b1);
        push2(2'b11, 1'b1);
        push2(2'b00, 1'b1);
        push2(2'b01, 1'b0);
        repeat (8) @(negedge clk);
        chk("pam_len",   64'(chips2.size() - base), 64'd16);
        chk("pam_burst", 64'(rises2 - rb), 64'd1);
        chk("pam0", 64'(pam_of(base)),      64'd2);
        chk("pam1", 64'(pam_of(base + 4)),  64'd3);
        chk("pam2", 64'(pam_of(base + 8)),  64'd0);
        chk("pam3", 64'(pam_of(base + 12)), 64'd1);
        chk("pam_cnt", 64'(cnt2), 64'd8);

        // Reset after five chips of 8'hC3.
        base = chips8.size();
        push8(8'hC3, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_mout",  64'(mout8), 64'd0);
        chk("mid_line",  64'(line8), 64'd0);
        chk("mid_cnt",   64'(cnt8), 64'd0);
        chk("mid_len",   64'(chips8.size() - base), 64'd5);
        chk("mid_chips", vec8(base, 5), 64'b10100);
        @(negedge clk);
        #1;
        chk("mid_hold", 64'({bus8.data_ready, line8, mout8}), 64'b100);
        @(negedge clk);
        rst  = 1'b1;
        base = chips8.size();
        push8(8'h3C, 1'b0);
        repeat (20) @(negedge clk);
        chk("post_len",   64'(chips8.size() - base), 64'd16);
        chk("post_chips", vec8(base, 16), 64'h5AA5);
        chk("post_cnt",   64'(cnt8), 64'd8);

        // Counter wrap from 65530 across one 8-bit word.
        force dut8.bits_sent = 16'd65530;
        @(negedge clk);
        release dut8.bits_sent;
        @(negedge clk);
        chk("wrap_pre", 64'(cnt8), 64'd65530);
        push8(8'h5A, 1'b0);
        repeat (20) @(negedge clk);
        chk("wrap_cnt", 64'(cnt8), 64'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
